add_accum: RTL and testbench



---
 rtl/add_accum_if.sv | 30 +++
 rtl/add_accum.sv | 85 ++++++++
 tb/tb_add_accum.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/add_accum_if.sv
// Bundle of the sample input and frame-total output handshakes of add_accum.
// dbg_state mirrors the accumulator FSM state (0 = ACCUM, 1 = DONE).
interface add_accum_if #(
  parameter int WIDTH_IN = 3,
  parameter int ACC_W    = 8,
  parameter int MAX_CNT  = 8
);
  localparam int CNT_W = $clog2(MAX_CNT + 1);

  logic                in_valid;
  logic                in_ready;
  logic [WIDTH_IN-1:0] sum;
  logic [WIDTH_IN-1:0] cout;
  logic [ACC_W-1:0]    acc;
  logic                acc_valid;
  logic                acc_ready;
  logic [CNT_W-1:0]    count;
  logic                overflow;
  logic                dbg_state;

  modport slave (
    input  in_valid, sum, cout, acc_ready,
    output in_ready, acc, acc_valid, count, overflow, dbg_state
  );

  modport master (
    output in_valid, sum, cout, acc_ready,
    input  in_ready, acc, acc_valid, count, overflow, dbg_state
  );
endinterface

// File: rtl/add_accum.sv
// Frame accumulator for the ripple-carry adder output: sums MAX_CNT samples, then
// offers the total. Define ACCUM_SAT_EN to saturate instead of wrap on overflow.
module add_accum #(
  parameter int WIDTH_IN = 3,
  parameter int ACC_W    = 8,
  parameter int MAX_CNT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  add_accum_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_CNT + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready/acc_valid depend on state only, never on the partner's signals.
  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sample_v;
  logic [ACC_W:0]   sum_ext;
  logic             accept;
  logic             unused_cout;

  assign unused_cout = ^bus.cout;

  always_comb begin
    sample_v               = '0;
    sample_v[WIDTH_IN:0]   = {bus.cout[WIDTH_IN-1], bus.sum};
    sum_ext                = {1'b0, acc_q} + {1'b0, sample_v};
    accept                 = bus.in_valid && (state_q == ACCUM);

    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      ovf_d   = ovf_q | sum_ext[ACC_W];
      count_d = count_q + 1'b1;
`ifdef ACCUM_SAT_EN
      // Once pinned at all-ones, any nonzero sample carries again, so it stays pinned.
      acc_d   = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
      acc_d   = sum_ext[ACC_W-1:0];
`endif
      if (count_q == CNT_W'(MAX_CNT - 1)) state_d = DONE;
    end else if ((state_q == DONE) && bus.acc_ready) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.acc_valid = (state_q == DONE);
  assign bus.acc       = acc_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_add_accum.sv
// Bench for add_accum: a default-size instance and a small (ACC_W=6, MAX_CNT=5) one
// share the same stimulus and are checked against a frame-sum reference model.
module tb_add_accum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] sum = '0;
  logic [2:0] cout = '0;
  logic       acc_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  // Reference model: running frame total (plain integer) and sample count per instance.
  int tot [2];
  int cnt [2];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  add_accum_if #(.WIDTH_IN(3), .ACC_W(8), .MAX_CNT(8)) if0 ();
  add_accum_if #(.WIDTH_IN(3), .ACC_W(6), .MAX_CNT(5)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.sum       = sum;
  assign if0.cout      = cout;
  assign if0.acc_ready = acc_ready;
  assign if1.in_valid  = in_valid;
  assign if1.sum       = sum;
  assign if1.cout      = cout;
  assign if1.acc_ready = acc_ready;

  add_accum #(.WIDTH_IN(3), .ACC_W(8), .MAX_CNT(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0)
  );
  add_accum #(.WIDTH_IN(3), .ACC_W(6), .MAX_CNT(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1)
  );

  function automatic int max_cnt(int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic int acc_w(int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic int exp_acc(int total, int w);
    int lim;
    lim = 1 << w;
`ifdef ACCUM_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        tot[d] = 0;
        cnt[d] = 0;
      end
      exp_q.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (clear) begin
          tot[d] = 0;
          cnt[d] = 0;
          if (d == 0) exp_q.delete();
        end else if (cnt[d] < max_cnt(d)) begin
          if (in_valid) begin
            tot[d] = tot[d] + int'({cout[2], sum});
            cnt[d] = cnt[d] + 1;
            if (d == 0 && cnt[0] == max_cnt(0)) exp_q.push_back(8'(exp_acc(tot[0], 8)));
          end
        end else if (acc_ready) begin
          tot[d] = 0;
          cnt[d] = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int full0, full1;
    full0 = (cnt[0] == max_cnt(0)) ? 1 : 0;
    full1 = (cnt[1] == max_cnt(1)) ? 1 : 0;
    check("d0_acc",       int'(if0.acc),       exp_acc(tot[0], acc_w(0)));
    check("d0_count",     int'(if0.count),     cnt[0]);
    check("d0_acc_valid", int'(if0.acc_valid), full0);
    check("d0_in_ready",  int'(if0.in_ready),  1 - full0);
    check("d0_overflow",  int'(if0.overflow),  (tot[0] >= 256) ? 1 : 0);
    check("d1_acc",       int'(if1.acc),       exp_acc(tot[1], acc_w(1)));
    check("d1_count",     int'(if1.count),     cnt[1]);
    check("d1_acc_valid", int'(if1.acc_valid), full1);
    check("d1_in_ready",  int'(if1.in_ready),  1 - full1);
    check("d1_overflow",  int'(if1.overflow),  (tot[1] >= 64) ? 1 : 0);
    // A handshake is about to happen: the offered total must match the scoreboard.
    if (full0 == 1 && acc_ready && !clear) begin
      check("frame_q_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) check("frame_total", int'(if0.acc), int'(exp_q.pop_front()));
    end
  endtask

  // Inputs change at posedge+1; outputs are checked on the falling edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [2:0] s, input logic [2:0] c,
                       input logic ar, input logic clr);
    in_valid  = iv;
    sum       = s;
    cout      = c;
    acc_ready = ar;
    clear     = clr;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic clear_all();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    step();
    idle();
  endtask

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
    end
    idle();
    rst_n = 1'b1;
    #1;
    check("rst_acc",       int'(if0.acc),       0);
    check("rst_count",     int'(if0.count),     0);
    check("rst_acc_valid", int'(if0.acc_valid), 0);
    check("rst_overflow",  int'(if0.overflow),  0);
    check("rst_in_ready",  int'(if0.in_ready),  1);
    step();

    // Basic frame: 8 samples of v=13 with the consumer stalled
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'b101, 3'b100, 1'b0, 1'b0);
      step();
    end
    check("basic_acc",       int'(if0.acc),       104);
    check("basic_count",     int'(if0.count),     8);
    check("basic_acc_valid", int'(if0.acc_valid), 1);
    check("basic_in_ready",  int'(if0.in_ready),  0);
    check("basic_overflow",  int'(if0.overflow),  0);

    // Backpressure: samples offered while DONE are ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'($urandom), 3'($urandom), 1'b0, 1'b0);
      step();
    end
    check("bp_acc",       int'(if0.acc),       104);
    check("bp_acc_valid", int'(if0.acc_valid), 1);
    drive(1'b1, 3'b111, 3'b100, 1'b1, 1'b0);
    step();
    check("hs_acc",      int'(if0.acc),      0);
    check("hs_count",    int'(if0.count),    0);
    check("hs_in_ready", int'(if0.in_ready), 1);
    idle();
    step();

    // Overflow on the small instance: 5 x 15 = 75 against a 6-bit accumulator
    clear_all();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b111, 3'b100, 1'b0, 1'b0);
      step();
    end
`ifdef ACCUM_SAT_EN
    check("ovf_acc", int'(if1.acc), 63);
`else
    check("ovf_acc", int'(if1.acc), 11);
`endif
    check("ovf_flag",      int'(if1.overflow),  1);
    check("ovf_acc_valid", int'(if1.acc_valid), 1);
    drive(1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    step();
    check("ovf_cleared", int'(if1.overflow), 0);
    idle();

    // Clear mid-frame beats a coincident sample
    clear_all();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
      step();
    end
    check("clr_pre_acc", int'(if0.acc), 21);
    drive(1'b1, 3'b001, 3'b100, 1'b0, 1'b1);
    step();
    check("clr_acc",   int'(if0.acc),   0);
    check("clr_count", int'(if0.count), 0);
    idle();
    step();

    // Async reset between edges
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'($urandom), 3'($urandom), 1'b0, 1'b0);
      step();
    end
    check("arst_pre_count", int'(if0.count), 4);
    idle();
    rst_n = 1'b0;
    #1;
    check("arst_acc",       int'(if0.acc),       0);
    check("arst_count",     int'(if0.count),     0);
    check("arst_acc_valid", int'(if0.acc_valid), 0);
    check("arst_in_ready",  int'(if0.in_ready),  1);
    check("arst_overflow",  int'(if0.overflow),  0);
    #1;
    rst_n = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
